// File: rtl/h2bp_alu_seq.sv
// Sequential H2BP ALU: single-cycle arithmetic/logic/shift ops plus iterative
// shift-add multiply and restoring divide, behind valid/ready handshakes.
module h2bp_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic [3:0]       flags,
  output logic             div_by_zero
);

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_MULT   = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd3;
  localparam logic [2:0] OP_AND    = 3'd4;
  localparam logic [2:0] OP_OR     = 3'd5;
  localparam logic [2:0] OP_LSHIFT = 3'd6;
  localparam logic [2:0] OP_RSHIFT = 3'd7;

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_VAL   = WIDTH'(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, lo_q, opnd_q;
  logic             accept, busy, last;

  logic [WIDTH:0]   sum_ext, dif_ext, shl_ext, shr_ext;
  logic             big_shift;
  logic [WIDTH-1:0] fast_res, fast_rem;
  logic             fast_c, fast_v, fast_dbz;

  logic [WIDTH:0]   mul_sum, div_sh, div_df;
  logic [WIDTH-1:0] mul_acc_n, mul_lo_n, div_acc_n, div_lo_n;

  // Flag vector layout: {zero, negative, carry, overflow}.
  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
    return {(r == '0), r[WIDTH-1], c, v};
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && (state_q == IDLE);
  assign busy      = (state_q == MUL) || (state_q == DIV);
  assign last      = (cnt_q == CNT_LAST);

  always_comb begin
    sum_ext   = {1'b0, a} + {1'b0, b};
    dif_ext   = {1'b0, a} - {1'b0, b};
    shl_ext   = {1'b0, a} << b;
    shr_ext   = {a, 1'b0} >> b;
    big_shift = (b >= W_VAL);
    fast_res  = '0;
    fast_rem  = '0;
    fast_c    = 1'b0;
    fast_v    = 1'b0;
    fast_dbz  = 1'b0;
    case (op)
      OP_ADD: begin
        fast_res = sum_ext[WIDTH-1:0];
        fast_c   = sum_ext[WIDTH];
        fast_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        fast_res = dif_ext[WIDTH-1:0];
        fast_c   = dif_ext[WIDTH];
        fast_v   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: fast_res = a & b;
      OP_OR:  fast_res = a | b;
      // Extra bit above/below the operand catches the last bit shifted out.
      OP_LSHIFT: if (!big_shift) begin
        fast_res = shl_ext[WIDTH-1:0];
        fast_c   = shl_ext[WIDTH];
      end
      OP_RSHIFT: if (!big_shift) begin
        fast_res = shr_ext[WIDTH:1];
        fast_c   = shr_ext[0];
      end
      // Only reaches the output path when the divisor is zero.
      OP_DIV: begin
        fast_res = '1;
        fast_rem = a;
        fast_dbz = 1'b1;
        fast_v   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc_n = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_sh    = {acc_q, lo_q[WIDTH-1]};
    div_df    = div_sh - {1'b0, opnd_q};
    div_acc_n = div_df[WIDTH] ? div_sh[WIDTH-1:0] : div_df[WIDTH-1:0];
    div_lo_n  = {lo_q[WIDTH-2:0], ~div_df[WIDTH]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (op == OP_MULT)                  state_d = MUL;
        else if (op == OP_DIV && b != '0)   state_d = DIV;
        else                                state_d = DONE;
      end
      MUL:     if (last) state_d = DONE;
      DIV:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      result      <= '0;
      remainder   <= '0;
      flags       <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept)             cnt_q <= '0;
      else if (busy && !last) cnt_q <= cnt_q + CW'(1);

      if (accept && state_d == DONE) begin
        result      <= fast_res;
        remainder   <= fast_rem;
        flags       <= pack_flags(fast_res, fast_c, fast_v);
        div_by_zero <= fast_dbz;
      end else if (state_q == MUL && last) begin
        result      <= mul_lo_n;
        remainder   <= '0;
        flags       <= pack_flags(mul_lo_n, (mul_acc_n != '0), 1'b0);
        div_by_zero <= 1'b0;
      end else if (state_q == DIV && last) begin
        result      <= div_lo_n;
        remainder   <= div_acc_n;
        flags       <= pack_flags(div_lo_n, 1'b0, 1'b0);
        div_by_zero <= 1'b0;
      end
    end
  end

  // Iteration datapath: {acc_q, lo_q} is the running product or {remainder, quotient}
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q  <= '0;
      lo_q   <= (op == OP_MULT) ? b : a;
      opnd_q <= (op == OP_MULT) ? a : b;
    end else if (state_q == MUL) begin
      acc_q <= mul_acc_n;
      lo_q  <= mul_lo_n;
    end else if (state_q == DIV) begin
      acc_q <= div_acc_n;
      lo_q  <= div_lo_n;
    end
  end

endmodule

// File: doc/h2bp_alu_seq.md
Name: h2bp_alu_seq

Overview:
Parametrised successor to the H2BP single-width ALU datapath. It executes the eight `operations` encodings (opADD..opRSHIFT) on WIDTH-bit operands and returns a result plus the packed `flags` struct. MULT runs on an iterative shift-add engine and DIV on an iterative restoring engine. Valid/ready handshakes on both sides let the execute stage stall on multi-cycle ops.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 4..64.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset; one clock; asynchronous, active-low
in_valid  in  1  operation request valid
in_ready  out  1  block can accept request
op  in  3  h2bp::operations encoding (opADD=0 ... opRSHIFT=7)
a  in  WIDTH  operand A (dividend / shiftee)
b  in  WIDTH  operand B (divisor / shift amount)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  result (MULT: low half; DIV: quotient)
remainder  out  WIDTH  DIV remainder; 0 for other ops
flags  out  4  h2bp::flags {zero,negative,carry,overflow}
div_by_zero  out  1  DIV with b==0

Behaviour:
- Reset (async assert): state IDLE; in_ready=1 once released; out_valid=0; result, remainder, flags and div_by_zero all 0; any in-flight MULT/DIV aborted, nothing emitted.
- FSM states IDLE, MUL, DIV, DONE.
- in_ready=1 only in IDLE. A request is accepted when in_valid&&in_ready at a clock edge; operands and op are captured.
- From IDLE:
  - ADD/SUB/AND/OR/LSHIFT/RSHIFT, and DIV with b==0 -> DONE. Latency 1: out_valid high at the next edge.
  - MULT -> MUL; DIV with b!=0 -> DIV.
- MUL / DIV each run a WIDTH-bit iteration counter, one bit per cycle. After WIDTH cycles -> DONE, so out_valid rises WIDTH+1 edges after accept.
- DONE: out_valid=1; all outputs held stable until out_ready. On out_valid&&out_ready -> IDLE.
  - Throughput at most one op per 2 cycles; no bypass of DONE.
- All output changes are registered. in_valid is ignored outside IDLE.
- Flags (common to all ops): zero = (result==0); negative = result[WIDTH-1].
- ADD: result = (a+b) mod 2^WIDTH.
  - carry = carry-out.
  - overflow = signed overflow (operand signs equal, result sign differs).
- SUB: result = a-b.
  - carry = borrow (a<b unsigned).
  - overflow = signed overflow (operand signs differ, result sign differs from a).
- AND / OR: bitwise; carry=0, overflow=0.
- LSHIFT / RSHIFT: logical shift; shift amount = full unsigned b.
  - b==0: result=a, carry=0.
  - 0<b<WIDTH: carry = last bit shifted out (LSHIFT: a[WIDTH-b]; RSHIFT: a[b-1]).
  - b>=WIDTH: result=0, carry=0.
  - overflow=0.
- MULT: unsigned 2*WIDTH product; result = low WIDTH bits; carry = (high half != 0); overflow=0.
- DIV: unsigned restoring division; result=quotient, remainder=remainder, carry=0, overflow=0.
  - b==0: result all ones, remainder=a, div_by_zero=1, overflow=1, carry=0.
- div_by_zero and remainder are 0 for every non-DIV op.
- Reset asserted mid-MUL/DIV or while in DONE: the pending result is discarded.

Test Plan:
- WIDTH=8: ADD a=0x7F b=0x01 -> out_valid 1 cycle after accept, result=0x80, flags Z0 N1 C0 V1. ADD 0xFF+0x01 -> 0x00, Z1 C1 V0.
- SUB a=0x05 b=0x07 -> result=0xFE, Z0 N1 C1 V0. SUB 0x80-0x01 -> 0x7F, V1 C0.
- MULT a=0x10 b=0x11 -> in_ready low 9 cycles, out_valid exactly 9 edges after accept, result=0x10, carry=1, overflow=0.
- DIV a=200 b=7 -> 9-cycle latency, result=0x1C, remainder=0x04, div_by_zero=0. DIV a=5 b=0 -> 1-cycle latency, result=0xFF, remainder=0x05, div_by_zero=1, V=1.
- Shifts: LSHIFT a=0x81 b=1 -> 0x02, C=1. RSHIFT a=0x81 b=1 -> 0x40, C=1. LSHIFT a=0x81 b=8 -> 0x00, Z=1, C=0. LSHIFT a=0x81 b=200 -> 0x00.
- Backpressure/reset: hold out_ready=0 for 3 cycles after a result -> outputs stable, in_ready=0, new in_valid ignored. Assert rst_n=0 at cycle 4 of DIV -> out_valid=0 and outputs 0 immediately, in_ready=1 after release, no stale result ever appears.
